imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Streams a program from a byte-serial link into instruction memory, holding
//  the multicycle MIPS core in reset until loading finishes. Sits directly
//  upstream of the CPU top: it drives the core's reset and the instruction
//  memory write port. The core starts fetching at BASE_ADDR once cpu_rst falls.
// PARAMETERS
//  ADDR_W     10  instruction-memory word-address width
//  BASE_ADDR  0   word address of the first loaded instruction
//  MAX_WORDS  1024  largest accepted word count; a larger count is an error
// PORTS
//  clk       in   1       system clock; all logic on rising edge
//  rst       in   1       synchronous, active-high reset
//  rx_valid  in   1       byte available on rx_data
//  rx_data   in   8       incoming byte
//  rx_ready  out  1       loader accepts a byte; a transfer occurs when rx_valid & rx_ready
//  im_we     out  1       one-cycle instruction-memory write strobe
//  im_addr   out  ADDR_W  write word address
//  im_wdata  out  32      write data
//  cpu_rst   out  1       reset to the CPU top; high until load completes
//  done      out  1       load completed successfully (sticky)
//  err       out  1       load aborted (sticky)
// BEHAVIOUR
//  - Reset values: rx_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0,
//    cpu_rst=1, done=0, err=0, state=LEN_HI, byte/word counters=0.
//  - Reset mid-load restarts from LEN_HI; memory already written is not cleared.
//  - Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words
//    of 4 bytes each, big-endian (first byte -> im_wdata[31:24]).
//  - FSM: LEN_HI -> LEN_LO -> DATA -> [CHK] -> DONE; any state -> ERR on error.
//    * LEN_HI/LEN_LO: each advances on one transfer.
//    * After LEN_LO: N > MAX_WORDS -> ERR. N == 0 -> CHK (with macro) or DONE.
//    * DATA: 4 transfers assemble a word. im_we pulses, with im_addr/im_wdata
//      valid, the cycle after the 4th transfer. im_addr = BASE_ADDR + index,
//      modulo 2^ADDR_W (wraps silently). After word N-1 -> CHK or DONE.
//    * DONE/ERR: terminal until rst; rx_ready=0, incoming bytes ignored.
//  - rx_ready=1 in LEN_HI, LEN_LO, DATA and CHK, including the im_we cycle.
//    The next word assembles concurrently; there is no back-pressure gap.
//    Throughput is 1 byte/cycle.
//  - done and cpu_rst change on the same edge. With macro undefined:
//    in the cycle after the final im_we, done=1 and cpu_rst=0.
//    For N=0: the cycle after the LEN_LO transfer.
//  - On ERR: err=1, cpu_rst stays 1, done stays 0.
//  - rx_valid without rx_ready is held off by the source; the loader never drops
//    a byte that was accepted by a transfer.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: CHK state follows the last data word (or LEN_LO
//    when N=0). Exactly one trailing byte is expected there.
//    Valid when the mod-256 sum of all frame bytes (length, data, checksum) is
//    0x00 -> DONE the next cycle. Otherwise -> ERR.
//    im_we writes still occur before the check, but cpu_rst is not released
//    on a mismatch.
//  BOOT_CHECKSUM_EN undefined: no CHK state, no checksum hardware; DATA -> DONE
//    directly; a trailing byte is simply never accepted.
// TESTING
//  1 N=2, words 0x20080005, 0x21090003 -> im_we at addr 0 then 1 with those
//    values. done=1 and cpu_rst=0 one cycle after the 2nd im_we; err=0.
//  2 N=0 -> no im_we; done=1 one cycle after LEN_LO (CHK byte 0x00 with macro).
//  3 Count 0x0401 with MAX_WORDS=1024 -> err=1 after LEN_LO; cpu_rst=1;
//    rx_ready=0 thereafter.
//  4 rx_valid gaps of 0-3 random cycles inside words -> identical im_addr/im_wdata
//    sequence as the back-to-back case.
//  5 Assert rst after 6 data bytes, then send a full N=1 frame 0xDEADBEEF ->
//    single write at BASE_ADDR; done=1.
//  6 (BOOT_CHECKSUM_EN) N=1 word 0x00000001, checksum 0xFE -> done=1.
//    Checksum 0xFF -> err=1, cpu_rst=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Streams a program from a byte-serial link into instruction memory while
//   holding the CPU in reset. Frame: 16-bit big-endian word count N, then N
//   big-endian 32-bit words. Each assembled word is written with a one-cycle
//   im_we strobe at BASE_ADDR + index (wrapping modulo 2^ADDR_W). cpu_rst is
//   released together with done once the whole frame has been written.
//
//   Optional feature: define BOOT_CHECKSUM_EN to require one trailing byte
//   that makes the mod-256 sum of all frame bytes zero; a mismatch ends in the
//   error state with the CPU still held in reset.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   rx_valid  in   byte available on rx_data
//   rx_data   in   incoming byte
//   rx_ready  out  loader accepts a byte (transfer = rx_valid & rx_ready)
//   im_we     out  one-cycle instruction-memory write strobe
//   im_addr   out  write word address
//   im_wdata  out  write data
//   cpu_rst   out  reset to the CPU, high until load completes
//   done      out  load completed (sticky until rst)
//   err       out  load aborted (sticky until rst)
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
`endif

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [23:0]         shift_q, shift_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                done_now;
    logic                xfer;
    logic [15:0]         len_full;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          sum_next;
`endif

    assign xfer     = rx_valid & ready_q;
    assign len_full = {len_q[15:8], rx_data};
`ifdef BOOT_CHECKSUM_EN
    assign sum_next = sum_q + rx_data;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_now   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
`ifdef BOOT_CHECKSUM_EN
                    sum_d       = sum_next;
`endif
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
`ifdef BOOT_CHECKSUM_EN
                    sum_d = sum_next;
`endif
                    if (32'(len_full) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        // Empty program: release the CPU on this very edge.
                        state_d  = S_DONE;
                        done_now = 1'b1;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], rx_data};
`ifdef BOOT_CHECKSUM_EN
                    sum_d      = sum_next;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {shift_q, rx_data};
                        addr_d     = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == len_q) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            // done follows one cycle later, after the write strobe.
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    if (sum_next == 8'h00) begin
                        state_d  = S_DONE;
                        done_now = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
`endif
            S_DONE: ;
            S_ERR:  ;
            default: state_d = S_LEN_HI;
        endcase

        ready_d   = (state_d != S_DONE) && (state_d != S_ERR);
        done_d    = done_q | done_now | (state_q == S_DONE);
        err_d     = err_q | (state_d == S_ERR);
        cpu_rst_d = ~done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LEN_HI;
            ready_q    <= 1'b0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rx_ready = ready_q;
    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
